// File: rtl/reg_write_arbiter.sv
// Register-file write port arbiter: the WB stage has priority, long-latency results queue in a FIFO
// and drain into idle slots, and a pending scoreboard tracks registers still owed a result.
module reg_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_wn,
  input  logic [31:0] wb_wd,
  input  logic        lu_valid,
  input  logic [4:0]  lu_wn,
  input  logic [31:0] lu_wd,
  output logic        lu_ready,
  input  logic        pend_set,
  input  logic [4:0]  pend_wn,
  input  logic [4:0]  q_rn1,
  input  logic [4:0]  q_rn2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        stall_req,
  output logic        err,
  output logic        RegWrite,
  output logic [4:0]  WN,
  output logic [31:0] WD
);
  // Handshake: a long-latency result transfers when lu_valid && lu_ready at a posedge.
  // lu_ready is !full and depends only on the registered count, never on lu_valid.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [4:0]    fifo_wn [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_next;
  logic [7:0]    wait_cnt, wait_next;
  logic [31:1]   pending;
  logic [31:0]   pend_vec, clr_mask, set_mask;

  logic wb_real, fifo_ne, pop, push, drop, stall_next;
  logic [4:0] head_wn;

  always_comb begin
    wb_real  = wb_valid && (wb_wn != 5'd0);
    fifo_ne  = (count != '0);
    lu_ready = (count != FULL_COUNT);
    head_wn  = fifo_wn[rd_ptr];
    // The head drains whenever WB is idle, and always while stalling.
    pop      = fifo_ne && (stall_req || !wb_real);
    // Zero-destination results are accepted but never stored.
    push     = lu_valid && lu_ready && (lu_wn != 5'd0);
    drop     = stall_req && fifo_ne && wb_real;

    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;

    wait_next = wait_cnt;
    if (!fifo_ne || pop)
      wait_next = 8'd0;
    else if (wait_cnt != LIMIT)
      wait_next = wait_cnt + 8'd1;

    stall_next = (wait_cnt == LIMIT) || (stall_req && (count_next != '0));

    clr_mask = 32'd0;
    if (pop)
      clr_mask[head_wn] = 1'b1;
    set_mask = 32'd0;
    if (pend_set && (pend_wn != 5'd0))
      set_mask[pend_wn] = 1'b1;

    pend_vec = {pending, 1'b0};
    q_busy1  = pend_vec[q_rn1] && (q_rn1 != 5'd0);
    q_busy2  = pend_vec[q_rn2] && (q_rn2 != 5'd0);
  end

  // Storage carries no reset; only the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wn[wr_ptr] <= lu_wn;
      fifo_wd[wr_ptr] <= lu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wait_cnt  <= 8'd0;
      stall_req <= 1'b0;
      err       <= 1'b0;
      pending   <= '0;
      RegWrite  <= 1'b0;
      WN        <= 5'd0;
      WD        <= 32'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      wait_cnt  <= wait_next;
      stall_req <= stall_next;
      if (drop)
        err <= 1'b1;
      // A set in the same cycle as a clear wins: a newer op is outstanding.
      pending   <= (pending & ~clr_mask[31:1]) | set_mask[31:1];
      RegWrite  <= pop || wb_real;
      if (pop) begin
        WN <= head_wn;
        WD <= fifo_wd[rd_ptr];
      end else if (wb_real) begin
        WN <= wb_wn;
        WD <= wb_wd;
      end
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based behavioural model.
module tb_reg_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_wn = '0;
  logic [31:0] wb_wd = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_wn = '0;
  logic [31:0] lu_wd = '0;
  logic        lu_ready;
  logic        pend_set = 1'b0;
  logic [4:0]  pend_wn = '0;
  logic [4:0]  q_rn1 = '0;
  logic [4:0]  q_rn2 = '0;
  logic        q_busy1, q_busy2, stall_req, err, RegWrite;
  logic [4:0]  WN;
  logic [31:0] WD;

  reg_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_wn(wb_wn), .wb_wd(wb_wd),
    .lu_valid(lu_valid), .lu_wn(lu_wn), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .pend_set(pend_set), .pend_wn(pend_wn),
    .q_rn1(q_rn1), .q_rn2(q_rn2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .stall_req(stall_req), .err(err),
    .RegWrite(RegWrite), .WN(WN), .WD(WD)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  // Behavioural model: a queue of outstanding results and a flat pending array.
  logic [4:0]  exp_wn_q[$];
  logic [31:0] exp_wd_q[$];
  logic [31:0] m_pend;
  int          m_wait;
  bit          m_stall, m_err, m_rw;
  logic [4:0]  m_wn;
  logic [31:0] m_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit wb_r, ne, pop, push;
    int sz, old_wait;
    if (rst) begin
      exp_wn_q.delete();
      exp_wd_q.delete();
      m_pend = '0; m_wait = 0; m_stall = 0; m_err = 0;
      m_rw = 0; m_wn = '0; m_wd = '0;
      return;
    end
    wb_r = wb_valid && (wb_wn != 0);
    sz = exp_wn_q.size();
    ne = (sz > 0);
    pop = ne && (m_stall || !wb_r);
    push = lu_valid && (sz < DEPTH) && (lu_wn != 0);
    old_wait = m_wait;
    m_rw = 0;
    if (pop) begin
      m_rw = 1;
      m_wn = exp_wn_q.pop_front();
      m_wd = exp_wd_q.pop_front();
      m_pend[m_wn] = 1'b0;
    end else if (wb_r) begin
      m_rw = 1; m_wn = wb_wn; m_wd = wb_wd;
    end
    if (m_stall && ne && wb_r) m_err = 1;
    if (pend_set && pend_wn != 0) m_pend[pend_wn] = 1'b1;
    if (push) begin
      exp_wn_q.push_back(lu_wn);
      exp_wd_q.push_back(lu_wd);
    end
    m_wait = (!ne || pop) ? 0 : ((old_wait < LIMIT) ? old_wait + 1 : LIMIT);
    m_stall = (old_wait == LIMIT) || (m_stall && exp_wn_q.size() != 0);
  endtask

  task automatic compare_all();
    chk("RegWrite", RegWrite, m_rw);
    chk("WN", WN, m_wn);
    chk("WD", WD, m_wd);
    chk("lu_ready", lu_ready, exp_wn_q.size() < DEPTH);
    chk("q_busy1", q_busy1, m_pend[q_rn1] && q_rn1 != 0);
    chk("q_busy2", q_busy2, m_pend[q_rn2] && q_rn2 != 0);
    chk("stall_req", stall_req, m_stall);
    chk("err", err, m_err);
  endtask

  // One cycle: compare mid-cycle, then advance model alongside the DUT at the edge.
  task automatic step();
    @(negedge clk);
    if (started) compare_all();
    @(posedge clk);
    model_update();
    if (rst) started = 1'b1;
    #1;
  endtask

  initial begin
    int n;
    int wb_pct;
    // Reset
    rst = 1; step(); step(); rst = 0;
    chk("rst_regwrite", RegWrite, 0); chk("rst_wn", WN, 0); chk("rst_wd", WD, 0);
    chk("rst_lu_ready", lu_ready, 1); chk("rst_stall", stall_req, 0); chk("rst_err", err, 0);

    // Plain WB write
    wb_valid = 1; wb_wn = 5; wb_wd = 32'h1234; step();
    wb_valid = 0;
    chk("wb_regwrite", RegWrite, 1); chk("wb_wn", WN, 5); chk("wb_wd", WD, 32'h1234);
    step();
    chk("wb_idle", RegWrite, 0); chk("wb_hold_wn", WN, 5);

    // Pending then long-latency write of r9
    pend_set = 1; pend_wn = 9; step(); pend_set = 0;
    q_rn1 = 9; #1;
    chk("busy_r9", q_busy1, 1);
    lu_valid = 1; lu_wn = 9; lu_wd = 7; step(); lu_valid = 0;
    chk("busy_r9_queued", q_busy1, 1); chk("lu_no_write_yet", RegWrite, 0);
    step();
    chk("lu_regwrite", RegWrite, 1); chk("lu_wn", WN, 9); chk("lu_wd", WD, 7);
    chk("busy_r9_cleared", q_busy1, 0);

    // Fill FIFO under continuous WB, starve into stall
    wb_valid = 1; wb_wn = 10; wb_wd = 32'hAAAA;
    for (int i = 1; i <= 4; i++) begin
      lu_valid = 1; lu_wn = 5'(i); lu_wd = 100 + i; step();
    end
    lu_valid = 0;
    chk("full_lu_ready", lu_ready, 0);
    for (int i = 0; i < 5; i++) step();
    chk("stall_not_yet", stall_req, 0);
    step();
    chk("stall_asserted", stall_req, 1);
    // WB during stall is dropped
    wb_wn = 3; wb_wd = 32'h3333; step(); wb_valid = 0;
    chk("drop_wn", WN, 1); chk("drop_wd", WD, 101); chk("drop_err", err, 1);
    step(); chk("drain_wn2", WN, 2);
    step(); chk("drain_wn3", WN, 3); chk("drain_wd3", WD, 103);
    step(); chk("drain_wn4", WN, 4); chk("drain_rw4", RegWrite, 1);
    chk("stall_released", stall_req, 0);
    step(); chk("drain_done", RegWrite, 0); chk("err_sticky", err, 1);

    // Set and clear of r7 in the same cycle
    pend_set = 1; pend_wn = 7; lu_valid = 1; lu_wn = 7; lu_wd = 32'h77; step();
    lu_valid = 0; step(); pend_set = 0;
    q_rn2 = 7; #1;
    chk("r7_wn", WN, 7); chk("r7_wd", WD, 32'h77); chk("r7_still_busy", q_busy2, 1);

    // Reset mid-operation
    wb_valid = 1; wb_wn = 11; pend_set = 1; pend_wn = 12;
    for (int i = 0; i < 3; i++) begin
      lu_valid = 1; lu_wn = 5'(20 + i); lu_wd = 32'h200 + i; step(); pend_set = 0;
    end
    lu_valid = 0;
    n = 0;
    while (!stall_req && n < 20) begin step(); n++; end
    chk("stall_before_reset", stall_req, 1);
    rst = 1; wb_valid = 0; q_rn1 = 12; step(); rst = 0;
    chk("mid_rst_rw", RegWrite, 0); chk("mid_rst_wn", WN, 0); chk("mid_rst_wd", WD, 0);
    chk("mid_rst_ready", lu_ready, 1); chk("mid_rst_stall", stall_req, 0);
    chk("mid_rst_err", err, 0); chk("mid_rst_busy", q_busy1, 0);
    for (int i = 0; i < 3; i++) begin step(); chk("post_rst_no_write", RegWrite, 0); end

    // Randomized run against the model
    wb_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) wb_pct = (c / 64) % 3 == 0 ? 20 : ((c / 64) % 3 == 1 ? 70 : 97);
      rst      = ($urandom_range(0, 399) == 0);
      wb_valid = ($urandom_range(0, 99) < wb_pct);
      wb_wn    = 5'($urandom_range(0, 31));
      wb_wd    = $urandom;
      lu_valid = ($urandom_range(0, 99) < 40);
      lu_wn    = 5'($urandom_range(0, 31));
      lu_wd    = $urandom;
      pend_set = ($urandom_range(0, 99) < 30);
      pend_wn  = 5'($urandom_range(0, 31));
      q_rn1    = 5'($urandom_range(0, 31));
      q_rn2    = 5'($urandom_range(0, 31));
      step();
    end
    rst = 0; wb_valid = 0; lu_valid = 0; pend_set = 0;
    for (int i = 0; i < 20; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
